// File: rtl/spi_stream_buffer.sv
// spi_stream_buffer: host-side TX/RX FIFOs around a start/done SPI master core.
// The sequencer issues one frame at a time and only when an RX slot is free,
// so received words can never be lost.
module spi_stream_buffer #(
    parameter int word_width = 8,
    parameter int depth      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [word_width-1:0]   tx_data,
    input  logic                    tx_write,
    output logic                    tx_full,
    output logic [$clog2(depth):0]  tx_count,
    output logic [word_width-1:0]   rx_data,
    input  logic                    rx_read,
    output logic                    rx_empty,
    output logic                    overflow,
    input  logic                    flag_clear,
    output logic                    busy,
    output logic                    ss_active,
    output logic                    spi_start,
    output logic [word_width-1:0]   spi_data_out,
    input  logic [word_width-1:0]   spi_data_in,
    input  logic                    spi_done
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;

    logic [word_width-1:0] tx_mem [depth];
    logic [AW-1:0]         tx_wr_ptr;
    logic [AW-1:0]         tx_rd_ptr;
    logic [CW-1:0]         tx_cnt;
    logic [CW-1:0]         tx_cnt_next;

    logic [word_width-1:0] rx_mem [depth];
    logic [AW-1:0]         rx_wr_ptr;
    logic [AW-1:0]         rx_rd_ptr;
    logic [CW-1:0]         rx_cnt;
    logic [CW-1:0]         rx_cnt_next;

    logic                  tx_push;
    logic                  tx_pop;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  start_ok;

    assign tx_push  = tx_write & ~tx_full;
    assign tx_pop   = (state == ISSUE);
    assign rx_push  = (state == WAIT) & spi_done;
    assign rx_pop   = rx_read & ~rx_empty;
    // Start only with a word to send and a guaranteed RX slot for its reply.
    assign start_ok = enable && (tx_cnt != '0) && (rx_cnt < CW'(depth));

    assign tx_cnt_next = tx_cnt + CW'(tx_push) - CW'(tx_pop);
    assign rx_cnt_next = rx_cnt + CW'(rx_push) - CW'(rx_pop);

    assign tx_count  = tx_cnt;
    assign rx_data   = rx_empty ? '0 : rx_mem[rx_rd_ptr];
    assign busy      = (state != IDLE);
    assign ss_active = (state == ISSUE) || (state == WAIT);
    assign spi_start = (state == ISSUE);

    // Sequencer next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (spi_done) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sequencer state and outgoing word, latched from the TX head on ISSUE entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            spi_data_out <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start_ok)
                spi_data_out <= tx_mem[tx_rd_ptr];
        end
    end

    // FIFO storage; contents need no reset because pointers and counts gate every read.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
        if (rx_push) rx_mem[rx_wr_ptr] <= spi_data_in;
    end

    // TX FIFO pointers, count and registered full flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
            tx_full   <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            tx_cnt  <= tx_cnt_next;
            tx_full <= (tx_cnt_next == CW'(depth));
        end
    end

    // RX FIFO pointers, count and registered empty flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
            rx_empty  <= 1'b1;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            rx_cnt   <= rx_cnt_next;
            rx_empty <= (rx_cnt_next == '0);
        end
    end

    // Sticky overflow on a dropped write; a drop outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (tx_write && tx_full)
            overflow <= 1'b1;
        else if (flag_clear)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_spi_stream_buffer.sv
// tb_spi_stream_buffer: scenario tasks checked against a queue-based model of
// the buffer plus an SPI-core responder living inside tick().
module tb_spi_stream_buffer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [W-1:0]  tx_data;
    logic          tx_write;
    logic          tx_full;
    logic [CW-1:0] tx_count;
    logic [W-1:0]  rx_data;
    logic          rx_read;
    logic          rx_empty;
    logic          overflow;
    logic          flag_clear;
    logic          busy;
    logic          ss_active;
    logic          spi_start;
    logic [W-1:0]  spi_data_out;
    logic [W-1:0]  spi_data_in;
    logic          spi_done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    bit m_ovf;
    bit in_flight;
    bit auto_resp;
    bit loopback;
    int resp_wait;
    int turn;
    int xfers;

    always #5 clk = ~clk;

    spi_stream_buffer #(.word_width(W), .depth(D)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full), .tx_count(tx_count),
        .rx_data(rx_data), .rx_read(rx_read), .rx_empty(rx_empty),
        .overflow(overflow), .flag_clear(flag_clear),
        .busy(busy), .ss_active(ss_active), .spi_start(spi_start),
        .spi_data_out(spi_data_out), .spi_data_in(spi_data_in), .spi_done(spi_done)
    );

    task automatic m_reset();
        txq.delete();
        rxq.delete();
        m_ovf     = 0;
        in_flight = 0;
    endtask

    // One clock: model predicts the edge from the current inputs, then checks outputs.
    task automatic tick();
        bit push, drop, pop, cap, rd;
        logic [W-1:0] cap_data;
        logic [W-1:0] exp_rx;
        if (auto_resp) begin
            spi_done = 1'b0;
            if (in_flight && resp_wait == 0) begin
                spi_done    = 1'b1;
                spi_data_in = loopback ? spi_data_out : W'($urandom);
            end
        end
        push = tx_write && (txq.size() < D);
        drop = tx_write && (txq.size() >= D);
        pop  = (spi_start === 1'b1);
        cap  = spi_done && in_flight;
        rd   = rx_read && (rxq.size() > 0);
        cap_data = spi_data_in;
        if (pop) begin
            checks++;
            if (txq.size() == 0 || spi_data_out !== txq[0] || ss_active !== 1'b1) begin
                errors++;
                $display("FAIL issue_word: spi_data_out=%h ss_active=%b expected head=%h (queued %0d)",
                         spi_data_out, ss_active, (txq.size() > 0) ? txq[0] : 8'h00, txq.size());
            end
        end
        @(posedge clk);
        #1;
        if (rd) void'(rxq.pop_front());
        if (cap) begin
            rxq.push_back(cap_data);
            in_flight = 0;
            xfers++;
        end
        if (pop) begin
            void'(txq.pop_front());
            in_flight = 1;
            resp_wait = turn;
        end else if (in_flight && resp_wait > 0) begin
            resp_wait--;
        end
        if (push) txq.push_back(tx_data);
        if (drop) m_ovf = 1;
        else if (flag_clear) m_ovf = 0;
        if (auto_resp) spi_done = 1'b0;

        exp_rx = 8'h00;
        if (rxq.size() > 0) exp_rx = rxq[0];
        checks++;
        if (tx_count !== CW'(txq.size()) || tx_full !== (txq.size() == D)) begin
            errors++;
            $display("FAIL tx_state: tx_count=%0d tx_full=%b expected count=%0d", tx_count, tx_full, txq.size());
        end
        checks++;
        if (rx_empty !== (rxq.size() == 0) || rx_data !== exp_rx) begin
            errors++;
            $display("FAIL rx_state: rx_empty=%b rx_data=%h expected empty=%b data=%h",
                     rx_empty, rx_data, rxq.size() == 0, exp_rx);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow: got %b expected %b", overflow, m_ovf);
        end
        if (cap) begin
            checks++;
            if (ss_active !== 1'b0 || busy !== 1'b1 || spi_start !== 1'b0) begin
                errors++;
                $display("FAIL gap: ss_active=%b busy=%b spi_start=%b expected 0 1 0", ss_active, busy, spi_start);
            end
        end
        if (pop) begin
            checks++;
            if (ss_active !== 1'b1 || busy !== 1'b1 || spi_start !== 1'b0) begin
                errors++;
                $display("FAIL wait: ss_active=%b busy=%b spi_start=%b expected 1 1 0", ss_active, busy, spi_start);
            end
        end
    endtask

    task automatic wait_start(input int max, input string tag);
        int n = 0;
        while (spi_start !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (spi_start !== 1'b1) begin
            errors++;
            $display("FAIL %s: spi_start=%b expected 1 within %0d cycles", tag, spi_start, max);
        end
    endtask

    task automatic write_word(input logic [W-1:0] d);
        tx_data  = d;
        tx_write = 1'b1;
        tick();
        tx_write = 1'b0;
    endtask

    // Run the auto responder and read RX until everything has drained.
    task automatic drain(input int max, input string tag);
        int n = 0;
        auto_resp = 1;
        enable    = 1'b1;
        while ((txq.size() > 0 || in_flight || rxq.size() > 0 || busy !== 1'b0) && n < max) begin
            rx_read = (rxq.size() > 0);
            tick();
            n++;
        end
        rx_read   = 1'b0;
        auto_resp = 0;
        checks++;
        if (txq.size() > 0 || rxq.size() > 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: not drained, tx=%0d rx=%0d busy=%b expected 0 0 0", tag, txq.size(), rxq.size(), busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        checks++;
        if ({tx_full, tx_count, rx_empty, rx_data, overflow, busy, ss_active, spi_start, spi_data_out} !==
            {1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values: full=%b cnt=%0d empty=%b rx=%h ovf=%b busy=%b ss=%b start=%b out=%h",
                     tx_full, tx_count, rx_empty, rx_data, overflow, busy, ss_active, spi_start, spi_data_out);
        end
        reset   = 1'b1;
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
    endtask

    task automatic test_basic();
        enable = 1'b1;
        write_word(8'hA5);
        checks++;
        if (spi_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency1: spi_start=%b busy=%b expected 0 0", spi_start, busy);
        end
        tick();
        checks++;
        if (spi_start !== 1'b1 || spi_data_out !== 8'hA5 || ss_active !== 1'b1) begin
            errors++;
            $display("FAIL basic_issue: spi_start=%b out=%h ss=%b expected 1 a5 1", spi_start, spi_data_out, ss_active);
        end
        tick();
        repeat (4) tick();
        spi_done    = 1'b1;
        spi_data_in = 8'h3C;
        tick();
        spi_done    = 1'b0;
        checks++;
        if (rx_empty !== 1'b0 || rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL basic_rx: rx_empty=%b rx_data=%h expected 0 3c", rx_empty, rx_data);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || ss_active !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b ss=%b expected 0 0", busy, ss_active);
        end
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
    endtask

    task automatic test_overflow();
        enable = 1'b0;
        for (int i = 1; i <= 4; i++) write_word(W'(i));
        checks++;
        if (tx_full !== 1'b1 || tx_count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_full: tx_full=%b tx_count=%0d expected 1 4", tx_full, tx_count);
        end
        write_word(8'h05);
        checks++;
        if (overflow !== 1'b1 || tx_count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_drop: overflow=%b tx_count=%0d expected 1 4", overflow, tx_count);
        end
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%b expected 0", overflow);
        end
        flag_clear = 1'b1;
        write_word(8'h06);
        flag_clear = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: overflow=%b expected 1", overflow);
        end
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        turn = 1;
        drain(200, "ovf_drain");
    endtask

    task automatic test_stream();
        int sent = 0;
        int n = 0;
        logic [W-1:0] first;
        auto_resp = 1;
        loopback  = 0;
        turn      = 2;
        xfers     = 0;
        enable    = 1'b1;
        while (sent < 6 && n < 200) begin
            tx_write = (txq.size() < D);
            tx_data  = W'($urandom);
            if (tx_write) sent++;
            tick();
            n++;
        end
        tx_write = 1'b0;
        repeat (40) tick();
        checks++;
        if (xfers != 4 || tx_count !== 3'd2 || busy !== 1'b0 || rx_empty !== 1'b0) begin
            errors++;
            $display("FAIL stream_stall: xfers=%0d tx_count=%0d busy=%b rx_empty=%b expected 4 2 0 0",
                     xfers, tx_count, busy, rx_empty);
        end
        first = 8'h00;
        if (rxq.size() > 0) first = rxq[0];
        checks++;
        if (rx_data !== first) begin
            errors++;
            $display("FAIL stream_first: rx_data=%h expected %h", rx_data, first);
        end
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
        wait_start(4, "stream_resume");
        drain(300, "stream_drain");
    endtask

    task automatic test_enable_drop();
        auto_resp = 0;
        enable    = 1'b1;
        write_word(W'($urandom));
        wait_start(5, "en_start");
        tick();
        enable   = 1'b0;
        tx_data  = W'($urandom);
        tx_write = 1'b1;
        tick();
        tx_write = 1'b0;
        tick();
        spi_done    = 1'b1;
        spi_data_in = W'($urandom);
        tick();
        spi_done = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (spi_start !== 1'b0 || busy !== 1'b0 || tx_count !== 3'd1) begin
                errors++;
                $display("FAIL en_hold: spi_start=%b busy=%b tx_count=%0d expected 0 0 1", spi_start, busy, tx_count);
            end
            tick();
        end
        enable = 1'b1;
        wait_start(4, "en_resume");
        turn = 0;
        drain(200, "en_drain");
    endtask

    task automatic test_reset_mid();
        auto_resp = 0;
        enable    = 1'b1;
        write_word(W'($urandom));
        write_word(W'($urandom));
        wait_start(5, "rst_start");
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        checks++;
        if ({tx_full, tx_count, rx_empty, rx_data, overflow, busy, ss_active, spi_start, spi_data_out} !==
            {1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: full=%b cnt=%0d empty=%b rx=%h ovf=%b busy=%b ss=%b start=%b out=%h",
                     tx_full, tx_count, rx_empty, rx_data, overflow, busy, ss_active, spi_start, spi_data_out);
        end
        @(posedge clk);
        #1;
        reset       = 1'b1;
        spi_done    = 1'b1;
        spi_data_in = 8'hEE;
        tick();
        spi_done = 1'b0;
        checks++;
        if (rx_empty !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_done_ignored: rx_empty=%b busy=%b expected 1 0", rx_empty, busy);
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got  = 0;
        int n    = 0;
        auto_resp = 1;
        loopback  = 1;
        turn      = 1;
        enable    = 1'b1;
        while (got < 10 && n < 400) begin
            tx_write = (sent < 10) && (txq.size() < D);
            tx_data  = W'(8'h10 + sent);
            rx_read  = (rxq.size() > 0);
            if (rx_read) begin
                checks++;
                if (rx_data !== W'(8'h10 + got)) begin
                    errors++;
                    $display("FAIL wrap_order: rx_data=%h expected %h", rx_data, W'(8'h10 + got));
                end
                got++;
            end
            if (tx_write) sent++;
            tick();
            n++;
        end
        tx_write = 1'b0;
        rx_read  = 1'b0;
        loopback = 0;
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL wrap_count: received %0d expected 10", got);
        end
        drain(100, "wrap_drain");
    endtask

    task automatic test_concurrency();
        logic [W-1:0] cap;
        auto_resp = 0;
        enable    = 1'b0;
        for (int i = 0; i < 4; i++) write_word(W'($urandom));
        enable = 1'b1;
        wait_start(3, "cc_start1");
        tx_data  = 8'hAA;
        tx_write = 1'b1;
        tick();
        tx_write = 1'b0;
        checks++;
        if (tx_count !== 3'd3 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL cc_drop_with_pop: tx_count=%0d overflow=%b expected 3 1", tx_count, overflow);
        end
        flag_clear = 1'b1;
        tick();
        flag_clear  = 1'b0;
        spi_done    = 1'b1;
        spi_data_in = W'($urandom);
        tick();
        spi_done = 1'b0;
        wait_start(3, "cc_start2");
        tx_data  = 8'hBB;
        tx_write = 1'b1;
        tick();
        tx_write = 1'b0;
        checks++;
        if (tx_count !== 3'd3) begin
            errors++;
            $display("FAIL cc_push_with_pop: tx_count=%0d expected 3", tx_count);
        end
        cap         = W'($urandom);
        spi_done    = 1'b1;
        spi_data_in = cap;
        rx_read     = 1'b1;
        tick();
        spi_done = 1'b0;
        rx_read  = 1'b0;
        checks++;
        if (rx_empty !== 1'b0 || rx_data !== cap) begin
            errors++;
            $display("FAIL cc_read_with_capture: rx_empty=%b rx_data=%h expected 0 %h", rx_empty, rx_data, cap);
        end
        turn = 2;
        drain(300, "cc_drain");
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        tx_data     = '0;
        tx_write    = 1'b0;
        rx_read     = 1'b0;
        flag_clear  = 1'b0;
        spi_data_in = '0;
        spi_done    = 1'b0;
        auto_resp   = 0;
        loopback    = 0;
        turn        = 0;
        resp_wait   = 0;
        xfers       = 0;
        m_reset();

        test_reset();
        test_basic();
        test_overflow();
        test_stream();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        test_concurrency();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_stream_buffer.md
Name: spi_stream_buffer

Overview:
- Buffered front-end that sits directly upstream of the SPI master core.
- The host pushes words into a TX FIFO. A sequencer hands them one at a time to the SPI core using a start/done handshake.
- Each word received back from the SPI core is stored in an RX FIFO for the host to read.
- It decouples host timing from serial transfer time and guarantees that no RX word is ever dropped.

Parameters:
- word_width, 8, width of one SPI frame and of every data port.
- depth, 4, entries per FIFO; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new transfer is issued; a transfer in flight completes normally.
- tx_data  input  word_width  word to enqueue.
- tx_write  input  1  enqueue strobe.
- tx_full  output  1  TX FIFO holds depth words (registered).
- tx_count  output  $clog2(depth)+1  number of words in the TX FIFO.
- rx_data  output  word_width  head of the RX FIFO (first-word fall-through).
- rx_read  input  1  dequeue strobe.
- rx_empty  output  1  RX FIFO holds 0 words (registered).
- overflow  output  1  sticky; set by a dropped tx_write.
- flag_clear  input  1  synchronous clear of overflow.
- busy  output  1  sequencer not in IDLE.
- ss_active  output  1  chip-select request to the SPI core.
- spi_start  output  1  one-cycle transfer request to the SPI core.
- spi_data_out  output  word_width  word to shift out; held stable from the spi_start cycle until spi_done.
- spi_data_in  input  word_width  received word; valid in the spi_done cycle.
- spi_done  input  1  one-cycle completion pulse from the SPI core.

Behaviour:
- Reset (asynchronous, active-low):
  - Both FIFOs are emptied and their pointers zeroed.
  - Outputs after reset: tx_full=0, tx_count=0, rx_empty=1, rx_data=0, overflow=0, busy=0, ss_active=0, spi_start=0, spi_data_out=0.
  - The sequencer goes to IDLE.
  - Reset asserted mid-transfer abandons that transfer; the SPI core shares the same reset.
- TX FIFO:
  - A write is accepted when tx_write=1 and the registered tx_full=0.
  - tx_write=1 while tx_full=1 is dropped and sets overflow, even if a pop happens in the same cycle.
  - Pointers wrap modulo depth.
  - A simultaneous accepted write and a pop leave tx_count unchanged.
- RX FIFO:
  - A read is accepted when rx_read=1 and rx_empty=0; rx_read while empty is ignored with no flag.
  - rx_data shows the head combinationally from storage and reads 0 when empty.
  - Capture of spi_data_in and a read in the same cycle are both honoured.
- Sequencer states: IDLE, ISSUE, WAIT, GAP.
  - IDLE -> ISSUE when enable=1, tx_count>0 and rx count<depth, all evaluated on registered values.
  - ISSUE lasts one cycle:
    - spi_start=1 and ss_active=1.
    - spi_data_out is loaded with the TX head, registered at the entry edge so it is valid during ISSUE.
    - The TX head is popped. Next state is WAIT.
  - WAIT: ss_active=1, spi_data_out held.
    - On spi_done=1, spi_data_in is written into the RX FIFO at that edge; go to GAP.
    - A spi_done arriving in the ISSUE cycle is ignored; only WAIT observes it.
  - GAP lasts one cycle with ss_active=0 (minimum chip-select deassert time), then IDLE.
  - spi_done in IDLE or GAP is ignored.
  - A new start is decided at the earliest in the cycle after GAP, so back-to-back frames are at least 2 cycles apart.
- Latency:
  - From a tx_write into an empty, idle buffer to spi_start high is 2 cycles: count registered, then IDLE->ISSUE.
  - rx_empty deasserts on the edge after the spi_done cycle.
- busy=1 in ISSUE, WAIT and GAP.
- RX overrun is impossible: a transfer is only issued when an RX slot is free, and at most one transfer is ever in flight.
- Dropping enable during WAIT does not abort; the sequencer finishes GAP and then stays in IDLE.
- overflow: if flag_clear and a dropped write coincide, set wins.

Test Plan:
- Reset, then write 8'hA5 -> spi_start pulses 2 cycles later with spi_data_out=8'hA5 and ss_active=1. Drive spi_done with spi_data_in=8'h3C 5 cycles later -> rx_empty=0 and rx_data=8'h3C next cycle; ss_active low for one GAP cycle.
- With enable=0, write 8'h01..8'h04 -> tx_full=1 and tx_count=4. Write 8'h05 -> dropped, overflow=1. flag_clear -> overflow=0.
- Stream 6 words with a fixed 3-cycle spi_done turnaround and no rx_read:
  - Exactly 4 transfers complete, then the sequencer idles with tx_count=2 and busy=0.
  - One rx_read (rx_data=first received word) -> the 5th transfer starts.
- Transfer in WAIT, drop enable -> spi_done is still captured, GAP, then IDLE with tx_count unchanged; raise enable -> next spi_start.
- Assert reset during WAIT -> all outputs return to reset values immediately without waiting for a clock edge; a later spi_done is ignored and the RX FIFO stays empty.
- Wrap-around and concurrency:
  - Push and pop 10 words through the TX FIFO (depth 4); received words come out of RX in order 8'h10..8'h19.
  - In the same cycle assert tx_write (not full) and ISSUE pop -> tx_count unchanged.
  - In the same cycle assert rx_read and spi_done capture -> RX count unchanged.
